// File: rtl/wam_game.sv
// Whack-a-mole round controller on the 100 Hz game tick: spawns, lifetimes, hits, BCD score.
// Optional WAM_MISS_PENALTY_EN: tap edges on empty holes during RUN subtract from the score.
module wam_game #(
  parameter int ROUND_TICKS = 6000,
  parameter int SPAWN_EZ    = 100,
  parameter int SPAWN_MD    = 60,
  parameter int SPAWN_HD    = 30,
  parameter int LIFE_EZ     = 200,
  parameter int LIFE_MD     = 120,
  parameter int LIFE_HD     = 60
) (
  input  logic        clk_19,
  input  logic        clr,
  input  logic        strt,
  input  logic [1:0]  hrdn,
  input  logic [7:0]  tap,
  output logic [7:0]  holes,
  output logic [11:0] score,
  output logic        over,
  output logic [12:0] time_left
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t      state;
  logic [15:0] lfsr, lfsr_nxt;
  logic [7:0]  tap_q, tap_edge, hit;
  logic [7:0]  life [8];
  logic [15:0] spawn_cnt, spawn_reload;
  logic [7:0]  life_load;
  logic [9:0]  score_bin, score_nxt;
  logic [11:0] score_bcd_nxt;
  logic [2:0]  spawn_idx;
  int          sum;

  always_comb begin
    tap_edge = tap & ~tap_q;
    hit      = tap_edge & holes;
    unique case (hrdn)
      2'd0:    begin spawn_reload = 16'(SPAWN_EZ); life_load = 8'(LIFE_EZ); end
      2'd1:    begin spawn_reload = 16'(SPAWN_MD); life_load = 8'(LIFE_MD); end
      default: begin spawn_reload = 16'(SPAWN_HD); life_load = 8'(LIFE_HD); end
    endcase
    // Hits and misses are netted before clamping, so one tick can never overshoot 0 or 999.
    sum = int'(score_bin) + $countones(hit);
`ifdef WAM_MISS_PENALTY_EN
    sum = sum - $countones(tap_edge & ~holes);
`endif
    if (sum > 999) sum = 999;
    if (sum < 0)   sum = 0;
    score_nxt     = 10'(sum);
    score_bcd_nxt = {4'(score_nxt / 10'd100), 4'((score_nxt / 10'd10) % 10'd10), 4'(score_nxt % 10'd10)};
    // Galois right-shift form of x^16+x^14+x^13+x^11+1.
    lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    spawn_idx = lfsr[2:0];
  end

  always_ff @(posedge clk_19) begin
    if (clr) begin
      state     <= IDLE;
      holes     <= '0;
      score     <= '0;
      score_bin <= '0;
      over      <= 1'b0;
      time_left <= '0;
      spawn_cnt <= '0;
      lfsr      <= 16'hACE1;
      tap_q     <= 8'hFF;
      for (int i = 0; i < 8; i++) life[i] <= '0;
    end else begin
      lfsr  <= lfsr_nxt;
      tap_q <= tap;
      unique case (state)
        IDLE, OVER: if (strt) begin
          state     <= RUN;
          holes     <= '0;
          score     <= '0;
          score_bin <= '0;
          over      <= 1'b0;
          time_left <= 13'(ROUND_TICKS);
          spawn_cnt <= spawn_reload;
        end
        RUN: begin
          score     <= score_bcd_nxt;
          score_bin <= score_nxt;
          time_left <= time_left - 13'd1;
          for (int i = 0; i < 8; i++) begin
            if (hit[i]) holes[i] <= 1'b0;
            else if (holes[i]) begin
              if (life[i] == 8'd1) holes[i] <= 1'b0;
              life[i] <= life[i] - 8'd1;
            end
          end
          // Only an empty hole accepts a spawn, so a same-tick hit or expiry always wins.
          if (spawn_cnt == 16'd0) begin
            spawn_cnt <= spawn_reload;
            if (!holes[spawn_idx]) begin
              holes[spawn_idx] <= 1'b1;
              life[spawn_idx]  <= life_load;
            end
          end else begin
            spawn_cnt <= spawn_cnt - 16'd1;
          end
          if (time_left == 13'd1) begin
            state <= OVER;
            over  <= 1'b1;
            holes <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wam_game.md
WAM_GAME -- requirements
Module: wam_game

Interface
REQ-001 The block SHALL have parameter ROUND_TICKS, default 6000, meaning round length in clk_19 ticks (60 s at 100 Hz).
REQ-002 The block SHALL have parameter SPAWN_EZ / SPAWN_MD / SPAWN_HD, defaults 100 / 60 / 30, meaning ticks between spawn attempts per difficulty.
REQ-003 The block SHALL have parameter LIFE_EZ / LIFE_MD / LIFE_HD, defaults 200 / 120 / 60, meaning mole lifetime in ticks per difficulty (all ≤255).
REQ-004 The block SHALL have port clk_19, input, 1 bit: the single clock (100 Hz game tick); all logic rises on its posedge.
REQ-005 The block SHALL have port clr, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port strt, input, 1 bit: start request, level-sampled.
REQ-007 The block SHALL have port hrdn, input, 2 bits: difficulty; 0 easy, 1 medium, 2 and 3 hard.
REQ-008 The block SHALL have port tap, input, 8 bits: debounced hit switches, one per hole.
REQ-009 The block SHALL have port holes, output, 8 bits: mole present per hole.
REQ-010 The block SHALL have port score, output, 12 bits: 3-digit BCD score, [11:8] hundreds.
REQ-011 The block SHALL have port over, output, 1 bit: round finished.
REQ-012 The block SHALL have port time_left, output, 13 bits: ticks remaining in round.

Function
REQ-013 FSM states SHALL be IDLE, RUN, OVER: IDLE/OVER→RUN when strt=1; RUN→OVER on the tick time_left goes 1→0; strt SHALL be ignored in RUN.
REQ-014 RUN entry SHALL, in the same edge: holes=0, score=0, over=0, time_left=ROUND_TICKS, spawn counter=SPAWN_x for the current hrdn.
REQ-015 In RUN, time_left SHALL decrement by 1 per tick; in IDLE/OVER it SHALL hold.
REQ-016 A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) SHALL advance every tick in all states and never reach zero.
REQ-017 In RUN, the spawn counter SHALL decrement each tick; at 0, hole index i=lfsr[2:0] is attempted and the counter reloads from SPAWN_x using hrdn sampled that tick.
REQ-018 A spawn attempt on an empty hole SHALL set holes[i] and load life[i]=LIFE_x; on an occupied hole it SHALL be dropped (no retry).
REQ-019 Each occupied hole's life counter SHALL decrement per tick; a hole whose counter is 1 SHALL clear on the next edge (expiry, no score change).
REQ-020 Tap edges SHALL be tap & ~tap_q, tap_q being tap registered each tick; hit = edge & holes.
REQ-021 Hit holes SHALL clear on the next edge and score SHALL increase by popcount(hit) in BCD in the same edge, 1-cycle latency.
REQ-022 Score SHALL saturate at 999 BCD; no digit SHALL ever exceed 9.
REQ-023 Simultaneous hit and expiry on one hole SHALL count as a hit; simultaneous hit and spawn on the same hole SHALL clear it and drop the spawn.
REQ-024 Tap edges in IDLE/OVER SHALL be ignored; holes SHALL be 0 in IDLE and cleared on entry to OVER.
REQ-025 In OVER, over=1 and score SHALL hold until the next RUN entry.
REQ-026 A hrdn change mid-round SHALL affect only subsequent reloads/spawns, never live counters.

Reset
REQ-027 With clr=1 at a clk_19 edge: state=IDLE, holes=0, score=0, over=0, time_left=0, all life counters 0, spawn counter 0, lfsr=16'hACE1, tap_q=8'hFF.
REQ-028 clr SHALL take priority over strt, hits, spawns and expiry in the same edge, including mid-RUN.
REQ-029 The reset value tap_q=8'hFF SHALL be such that switches held up through reset produce no edge.

Configuration
REQ-030 Macro WAM_MISS_PENALTY_EN SHALL control miss handling; when defined, each tap edge on an empty hole in RUN decrements score by 1, saturating at 000, netted with hits in the same tick (net = hits − misses, clamped 0..999).
REQ-031 Without WAM_MISS_PENALTY_EN, tap edges on empty holes SHALL have no effect.

Verification
REQ-032 Scenario: clr 1 tick, then strt=1 → RUN next edge, time_left=6000, score=000, holes=00.
REQ-033 Scenario: hrdn=2, RUN, force a spawn on hole 3, toggle tap[3] 0→1 within 60 ticks → holes[3]=0 and score=001 one tick after the edge.
REQ-034 Scenario: mole left untouched → clears exactly LIFE_x ticks after spawn, score unchanged.
REQ-035 Scenario: score=998, two simultaneous hits → score=999; further hit → 999.
REQ-036 Scenario: run 6000 ticks → over=1, holes=00, score held; strt → RUN with score=000.
REQ-037 Scenario: WAM_MISS_PENALTY_EN defined, score=000, tap edge on empty hole → 000; with score=005, one hit plus two misses same tick → 004.
